// File: rtl/psum_reduce_unit.sv
`default_nettype none
// ============================================================================
//  Module      : psum_reduce_unit
//  Description : Reduces a frame of partial-sum rows (COL signed lanes per
//                row) to one signed frame total, either a plain sum or a sum
//                of absolute values. It has a two-stage pipeline: lane
//                conditioning, then an adder tree that feeds the accumulator.
//                A frame closes on in_last or when it reaches MAX_ROWS rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_reduce_unit #(
   parameter int COL      = 8,
   parameter int BW_PSUM  = 20,
   parameter int MAX_ROWS = 16,
   localparam int ROW_W   = $clog2(MAX_ROWS) + 1,
   localparam int SUM_W   = BW_PSUM + 1 + $clog2(COL) + $clog2(MAX_ROWS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COL*BW_PSUM-1:0] in_data,
   input  logic                   in_last,
   input  logic                   mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SUM_W-1:0]       out_sum,
   output logic [ROW_W-1:0]       out_count,
   output logic                   out_overrun
);

   // Sign-extension width used to grow a conditioned lane to accumulator width
   localparam int EXT_W = SUM_W - BW_PSUM - 1;
   // Row count just before the row that force-closes a frame
   localparam logic [ROW_W-1:0] LAST_CNT = ROW_W'(MAX_ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                   state;
   logic                     r_mode;
   logic [ROW_W-1:0]         r_count;
   logic                     r_overrun;
   logic                     r_s1_valid;
   logic [COL-1:0][BW_PSUM:0] r_s1;
   logic [SUM_W-1:0]         r_acc;

   logic                     w_xfer;
   logic                     w_mode_eff;
   logic [COL-1:0][BW_PSUM:0] w_s1_next;
   logic [SUM_W-1:0]         w_tree_sum;
   logic [SUM_W-1:0]         w_acc_next;

   assign w_xfer     = in_valid & in_ready;
   // The first row of a frame uses the live mode; later rows use the latched one
   assign w_mode_eff = (state == IDLE) ? mode : r_mode;
   assign w_acc_next = r_acc + w_tree_sum;

   // Stage-1 lane conditioning: widen by one bit so abs of the most negative value fits
   always_comb begin : b_lane_cond
      logic [BW_PSUM-1:0] lane;
      logic [BW_PSUM:0]   ext;
      w_s1_next = '0;
      for (int k = 0; k < COL; k++) begin
         lane = in_data[k*BW_PSUM +: BW_PSUM];
         ext  = {lane[BW_PSUM-1], lane};
         if (w_mode_eff && ext[BW_PSUM]) begin
            w_s1_next[k] = -ext;
         end else begin
            w_s1_next[k] = ext;
         end
      end
   end

   // Stage-2 lane adder tree at full accumulator precision
   always_comb begin : b_tree
      w_tree_sum = '0;
      for (int k = 0; k < COL; k++) begin
         w_tree_sum = w_tree_sum + {{EXT_W{r_s1[k][BW_PSUM]}}, r_s1[k]};
      end
   end

   // Datapath pipeline: stage-1 register and frame accumulator
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
         r_acc      <= '0;
      end else begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_s1 <= w_s1_next;
         end
         if (w_xfer && (state == IDLE)) begin
            r_acc <= '0;
         end else if (r_s1_valid) begin
            r_acc <= w_acc_next;
         end
      end
   end

   // Frame control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         r_mode      <= 1'b0;
         r_count     <= '0;
         r_overrun   <= 1'b0;
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_count   <= '0;
         out_overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (w_xfer) begin
                  r_mode    <= mode;
                  r_count   <= ROW_W'(1);
                  r_overrun <= 1'b0;
                  if (in_last) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (w_xfer) begin
                  r_count <= r_count + ROW_W'(1);
                  if (in_last || (r_count == LAST_CNT)) begin
                     state     <= DRAIN;
                     in_ready  <= 1'b0;
                     r_overrun <= ~in_last;
                  end
               end
            end
            DRAIN: begin
               // Closing row is in stage 1; it lands in the accumulator at this edge
               if (r_s1_valid) begin
                  state       <= HOLD;
                  out_valid   <= 1'b1;
                  out_sum     <= w_acc_next;
                  out_count   <= r_count;
                  out_overrun <= r_overrun;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psum_reduce_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_reduce_unit
//  Description : Self-checking bench for psum_reduce_unit. Directed frames
//                plus random frames checked against an arithmetic frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_reduce_unit;

   localparam int COL      = 8;
   localparam int BW       = 20;
   localparam int MAX_ROWS = 16;
   localparam int ROW_W    = $clog2(MAX_ROWS) + 1;
   localparam int SUM_W    = BW + 1 + $clog2(COL) + $clog2(MAX_ROWS);

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [COL*BW-1:0] in_data;
   logic              in_last;
   logic              mode;
   logic              out_valid;
   logic              out_ready;
   logic [SUM_W-1:0]  out_sum;
   logic [ROW_W-1:0]  out_count;
   logic              out_overrun;

   int errors = 0;
   int checks = 0;

   logic [COL*BW-1:0] frame_rows [MAX_ROWS];

   always #5 clk = ~clk;

   psum_reduce_unit #(
      .COL      (COL),
      .BW_PSUM  (BW),
      .MAX_ROWS (MAX_ROWS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .mode        (mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_count   (out_count),
      .out_overrun (out_overrun)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [COL*BW-1:0] rand_row(input int style);
      logic [COL*BW-1:0] r;
      logic [BW-1:0]     v;
      r = '0;
      for (int k = 0; k < COL; k++) begin
         if (style == 1) begin
            case ($urandom_range(0, 3))
               0:       v = {1'b1, {(BW-1){1'b0}}};
               1:       v = {1'b0, {(BW-1){1'b1}}};
               2:       v = '0;
               default: v = '1;
            endcase
         end else begin
            v = BW'($urandom);
         end
         r[k*BW +: BW] = v;
      end
      return r;
   endfunction

   function automatic logic [COL*BW-1:0] const_row(input int val);
      logic [COL*BW-1:0] r;
      r = '0;
      for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(val);
      return r;
   endfunction

   // Frame total from first principles: every lane of every row, abs when mode=1
   function automatic longint model_sum(input int n, input bit m);
      longint            s;
      longint            lv;
      logic signed [BW-1:0] lane;
      s = 0;
      for (int r = 0; r < n; r++) begin
         for (int k = 0; k < COL; k++) begin
            lane = frame_rows[r][k*BW +: BW];
            lv   = lane;
            if (m && lv < 0) lv = -lv;
            s += lv;
         end
      end
      return s;
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_data  = rand_row(0);
      in_last  = ($urandom_range(0, 1) == 1);
      mode     = ($urandom_range(0, 1) == 1);
   endtask

   // Present one row at a negedge; return at the negedge after its transfer
   task automatic send_row(input logic [COL*BW-1:0] d, input bit last, input bit m, input string tag);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      mode     = m;
      while (!in_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_ready_wait"}, guard < 40, 1);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic run_frame(input string tag, input int n, input bit m, input bit use_last,
                            input bit bubbles, input int hold, input logic signed [63:0] exp_sum);
      for (int r = 0; r < n; r++) begin
         if (bubbles && r > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_row(frame_rows[r], use_last && (r == n - 1),
                  (r == 0) ? m : ($urandom_range(0, 1) == 1), tag);
      end
      chk({tag, "_valid_t1"}, out_valid, 0);
      chk({tag, "_inready_t1"}, in_ready, 0);
      @(negedge clk);
      chk({tag, "_valid_t2"}, out_valid, 1);
      chk({tag, "_sum"}, $signed(out_sum), exp_sum);
      chk({tag, "_count"}, out_count, n);
      chk({tag, "_overrun"}, out_overrun, !use_last);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_inready"}, in_ready, 0);
         chk({tag, "_hold_sum"}, $signed(out_sum), exp_sum);
         chk({tag, "_hold_count"}, out_count, n);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_inready_rise"}, in_ready, 1);
      chk({tag, "_sum_kept"}, $signed(out_sum), exp_sum);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  m;
      bit  ul;
      int  sty;

      // Reset state
      reset     = 1'b0;
      out_ready = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_inready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", $signed(out_sum), 0);
      chk("rst_count", out_count, 0);
      chk("rst_overrun", out_overrun, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_inready", in_ready, 1);

      // Single row, lanes 1..8, plain sum, result held for 5 cycles
      for (int k = 0; k < COL; k++) frame_rows[0][k*BW +: BW] = BW'(k + 1);
      run_frame("one_row", 1, 1'b0, 1'b1, 1'b0, 5, 36);

      // Three rows of -5, abs then signed
      for (int r = 0; r < 3; r++) frame_rows[r] = const_row(-5);
      run_frame("neg5_abs", 3, 1'b1, 1'b1, 1'b0, 0, 120);
      run_frame("neg5_sum", 3, 1'b0, 1'b1, 1'b0, 1, -120);

      // Most negative lane value
      frame_rows[0] = const_row(-524288);
      run_frame("minval_abs", 1, 1'b1, 1'b1, 1'b0, 0, 4194304);
      run_frame("minval_sum", 1, 1'b0, 1'b1, 1'b0, 0, -4194304);

      // MAX_ROWS frames: forced close versus last on the final row
      for (int r = 0; r < MAX_ROWS; r++) frame_rows[r] = const_row(1);
      run_frame("max_nolast", MAX_ROWS, 1'b0, 1'b0, 1'b0, 0, 128);
      run_frame("max_last", MAX_ROWS, 1'b0, 1'b1, 1'b0, 0, 128);

      // Reset after 2 of 4 rows, then a fresh single-row frame
      for (int r = 0; r < 4; r++) frame_rows[r] = rand_row(0);
      send_row(frame_rows[0], 1'b0, 1'b1, "mid_rst");
      send_row(frame_rows[1], 1'b0, 1'b1, "mid_rst");
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_inready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      @(negedge clk);
      chk("mid_rst_count", out_count, 0);
      chk("mid_rst_sum", $signed(out_sum), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_inready_up", in_ready, 1);
      frame_rows[0] = const_row(2);
      run_frame("after_rst", 1, 1'b0, 1'b1, 1'b0, 0, 16);

      // Reset while a result is held: no later out_valid pulse
      frame_rows[0] = rand_row(0);
      send_row(frame_rows[0], 1'b1, 1'b0, "hold_rst");
      @(negedge clk);
      chk("hold_rst_valid_before", out_valid, 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("hold_rst_no_pulse", out_valid, 0);
      end
      chk("hold_rst_inready", in_ready, 1);

      // Random frames with bubbles, mid-frame mode noise and random hold times
      for (int i = 0; i < 24; i++) begin
         n   = $urandom_range(1, MAX_ROWS);
         m   = ($urandom_range(0, 1) == 1);
         ul  = (n == MAX_ROWS) ? ($urandom_range(0, 1) == 1) : 1'b1;
         sty = $urandom_range(0, 1);
         for (int r = 0; r < n; r++) frame_rows[r] = rand_row(sty);
         run_frame($sformatf("rnd%0d", i), n, m, ul, 1'b1, $urandom_range(0, 3), model_sum(n, m));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
